// File: rtl/multi_strip_pattern_sender.sv
// Multi-strip LED colour server. Each strip requests one LED colour at a
// time. Pending requests are arbitrated round-robin, and one colour is
// returned per grant, tagged with the strip and LED index. The colour comes
// from the active pattern mode: solid, chase, gradient or off.
//
// Handshake: there is no backpressure. next_led_request[i] is a one-cycle
// pulse that sets pending[i]. color_valid is a one-cycle strobe that qualifies
// color_strip/color_led/red/green/blue_out. Those fields hold their last value
// while color_valid is low. A request on a strip whose pending bit is still
// set, and which is not being granted that cycle, is dropped and raises the
// sticky overflow flag.
module multi_strip_pattern_sender #(
    parameter int NUM_STRIPS     = 11,
    parameter int LEDS_PER_STRIP = 60,
    parameter int COLOR_W        = 8,
    parameter int GRAD_STEP      = 4,
    localparam int SW = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1,
    localparam int LW = (LEDS_PER_STRIP > 1) ? $clog2(LEDS_PER_STRIP) : 1
) (
    input  logic                  clk_100mhz,
    input  logic                  rst_n,
    input  logic [NUM_STRIPS-1:0] next_led_request,
    input  logic                  cfg_load,
    input  logic [1:0]            cfg_mode,
    input  logic [COLOR_W-1:0]    cfg_red,
    input  logic [COLOR_W-1:0]    cfg_green,
    input  logic [COLOR_W-1:0]    cfg_blue,
    output logic [COLOR_W-1:0]    red_out,
    output logic [COLOR_W-1:0]    green_out,
    output logic [COLOR_W-1:0]    blue_out,
    output logic                  color_valid,
    output logic [SW-1:0]         color_strip,
    output logic [LW-1:0]         color_led,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam logic [1:0] MODE_SOLID = 2'd0;
    localparam logic [1:0] MODE_CHASE = 2'd1;
    localparam logic [1:0] MODE_GRAD  = 2'd2;
    localparam logic [1:0] MODE_OFF   = 2'd3;

    localparam logic [LW-1:0] LAST_LED   = LW'(LEDS_PER_STRIP - 1);
    localparam logic [LW:0]   LEDS_WIDE  = (LW + 1)'(LEDS_PER_STRIP);
    localparam logic [SW-1:0] LAST_STRIP = SW'(NUM_STRIPS - 1);

    // State registers
    logic [NUM_STRIPS-1:0] pending_q, pending_d;
    logic [LW-1:0]         led_cnt_q [NUM_STRIPS];
    logic [LW-1:0]         chase_pos_q;
    logic [SW-1:0]         rr_ptr_q;
    logic                  overflow_q;

    // Active configuration
    logic [1:0]            mode_q;
    logic [COLOR_W-1:0]    base_r_q, base_g_q, base_b_q;

    // Registered response
    logic [COLOR_W-1:0]    red_q, green_q, blue_q;
    logic                  valid_q, frame_done_q;
    logic [SW-1:0]         strip_q;
    logic [LW-1:0]         led_q;

    // Arbitration and response datapath
    logic                  grant_found;
    logic [SW-1:0]         grant_idx;
    logic [NUM_STRIPS-1:0] grant_mask;
    logic                  ovf_hit;
    logic [LW-1:0]         led_sel;
    logic                  last_led;
    logic [LW:0]           chase_sum;
    logic [LW:0]           chase_tgt;
    logic [COLOR_W-1:0]    resp_r, resp_g, resp_b;
    int                    scan_idx;

    // Round-robin scan: the first pending strip at or after rr_ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < NUM_STRIPS; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_STRIPS) scan_idx = scan_idx - NUM_STRIPS;
            if (!grant_found && pending_q[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = SW'(scan_idx);
            end
        end
    end

    // Pending update. A re-request on the strip granted this cycle simply re-arms it.
    always_comb begin
        grant_mask = grant_found ? (NUM_STRIPS'(1) << grant_idx) : '0;
        pending_d  = (pending_q & ~grant_mask) | next_led_request;
        ovf_hit    = |(next_led_request & pending_q & ~grant_mask);
    end

    // Colour generation for the granted strip using the currently active config.
    always_comb begin
        led_sel   = led_cnt_q[grant_idx];
        last_led  = (led_sel == LAST_LED);
        // chase_pos + strip stays below 2*LEDS_PER_STRIP, so one subtract is enough.
        chase_sum = {1'b0, chase_pos_q} + (LW + 1)'(grant_idx);
        chase_tgt = (chase_sum >= LEDS_WIDE) ? (chase_sum - LEDS_WIDE) : chase_sum;
        resp_r    = '0;
        resp_g    = '0;
        resp_b    = '0;
        case (mode_q)
            MODE_SOLID: begin
                resp_r = base_r_q;
                resp_g = base_g_q;
                resp_b = base_b_q;
            end
            MODE_CHASE: begin
                if ({1'b0, led_sel} == chase_tgt) begin
                    resp_r = base_r_q;
                    resp_g = base_g_q;
                    resp_b = base_b_q;
                end
            end
            MODE_GRAD: begin
                resp_r = base_r_q + COLOR_W'(led_sel) * COLOR_W'(GRAD_STEP);
                resp_g = base_g_q;
                resp_b = base_b_q;
            end
            MODE_OFF: begin
                resp_r = '0;
                resp_g = '0;
                resp_b = '0;
            end
            default: begin
                resp_r = '0;
                resp_g = '0;
                resp_b = '0;
            end
        endcase
    end

    // Pending bits, round-robin pointer and sticky overflow.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (ovf_hit) overflow_q <= 1'b1;
            if (grant_found) rr_ptr_q <= (grant_idx == LAST_STRIP) ? '0 : grant_idx + 1'b1;
        end
    end

    // Per-strip LED counters advance on each grant of that strip.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STRIPS; i++) led_cnt_q[i] <= '0;
        end else if (grant_found) begin
            led_cnt_q[grant_idx] <= last_led ? '0 : led_sel + 1'b1;
        end
    end

    // Chase position steps once per strip-0 frame.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            chase_pos_q <= '0;
        end else if (grant_found && grant_idx == '0 && last_led) begin
            chase_pos_q <= (chase_pos_q == LAST_LED) ? '0 : chase_pos_q + 1'b1;
        end
    end

    // Active configuration latches on cfg_load.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_SOLID;
            base_r_q <= '0;
            base_g_q <= '0;
            base_b_q <= '0;
        end else if (cfg_load) begin
            mode_q   <= cfg_mode;
            base_r_q <= cfg_red;
            base_g_q <= cfg_green;
            base_b_q <= cfg_blue;
        end
    end

    // Registered response. The fields hold their value between grants.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            red_q        <= '0;
            green_q      <= '0;
            blue_q       <= '0;
            strip_q      <= '0;
            led_q        <= '0;
        end else begin
            valid_q      <= grant_found;
            frame_done_q <= grant_found && (grant_idx == '0) && last_led;
            if (grant_found) begin
                red_q   <= resp_r;
                green_q <= resp_g;
                blue_q  <= resp_b;
                strip_q <= grant_idx;
                led_q   <= led_sel;
            end
        end
    end

    assign red_out     = red_q;
    assign green_out   = green_q;
    assign blue_out    = blue_q;
    assign color_valid = valid_q;
    assign color_strip = strip_q;
    assign color_led   = led_q;
    assign frame_done  = frame_done_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/multi_strip_pattern_sender.md
Name: multi_strip_pattern_sender

Overview:
Parametrised successor to the single-colour LED sender. It serves colour requests from NUM_STRIPS serial LED strip drivers. Each strip's LED index is tracked independently, and the colour for each LED is generated from a selectable pattern mode (solid, chase, gradient, off). Requests are arbitrated round-robin, and one colour is returned per grant, tagged with the strip and LED index.

Parameters:
NUM_STRIPS, 11, number of strip drivers / request lines
LEDS_PER_STRIP, 60, LEDs per strip; per-strip LED index wraps at LEDS_PER_STRIP-1
COLOR_W, 8, bits per colour channel
GRAD_STEP, 4, per-LED red increment in gradient mode

Ports:
clk_100mhz  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
next_led_request  input  NUM_STRIPS  per-strip one-cycle request pulse for the next LED colour
cfg_load  input  1  one-cycle pulse; latches cfg_mode and cfg_red/green/blue into active config
cfg_mode  input  2  0=solid, 1=chase, 2=gradient, 3=off
cfg_red  input  COLOR_W  base red
cfg_green  input  COLOR_W  base green
cfg_blue  input  COLOR_W  base blue
red_out  output  COLOR_W  response red
green_out  output  COLOR_W  response green
blue_out  output  COLOR_W  response blue
color_valid  output  1  one-cycle strobe; response fields valid
color_strip  output  clog2(NUM_STRIPS)  strip the response belongs to
color_led  output  clog2(LEDS_PER_STRIP)  LED index the response is for
frame_done  output  1  one-cycle pulse when strip 0 returns its last LED (index LEDS_PER_STRIP-1)
overflow  output  1  sticky; set when a request arrives on a strip whose pending bit is already set

Behaviour:
- Reset (rst_n low, async): all outputs 0. Pending bits, per-strip LED counters, chase_pos and rr_ptr are 0. Active config is mode=0 with colour 0.
- Pending: next_led_request[i]=1 sets pending[i].
  - If pending[i] is already set and is not being granted this cycle, the request is dropped and overflow is set (sticky until reset).
- Arbitration, each cycle:
  - Grant the first pending strip found scanning from rr_ptr upward with wraparound.
  - The granted pending bit clears. rr_ptr becomes grant+1, wrapping at NUM_STRIPS.
  - At most one grant per cycle.
- Simultaneous events on the granted strip:
  - A new request on the granted strip in its grant cycle re-sets pending (not an overflow).
  - A request and a grant on different strips proceed independently.
- Latency: request sampled at cycle N; earliest color_valid at N+2 (N+1 pending registered and grant; N+2 registered output). With one strip active, back-to-back requests every cycle are sustained.
- Response at grant of strip s, with led = led_cnt[s]:
  - color_strip=s, color_led=led, colour per active mode:
  - solid: base colour.
  - chase: base colour if led == (chase_pos + s) mod LEDS_PER_STRIP, else 0. Mod is done by a single conditional subtract, since chase_pos + s < 2*LEDS_PER_STRIP is required (NUM_STRIPS <= LEDS_PER_STRIP).
  - gradient: red = (base_red + led*GRAD_STEP) mod 2^COLOR_W; green and blue = base.
  - off: all 0.
  - After the response, led_cnt[s] increments, wrapping LEDS_PER_STRIP-1 to 0.
- frame_done and chase_pos:
  - When strip 0 is granted with led_cnt=LEDS_PER_STRIP-1, frame_done pulses in the same cycle as that color_valid.
  - chase_pos then increments, wrapping at LEDS_PER_STRIP-1.
- color_valid is low in cycles without a grant. Colour, strip and LED outputs hold their last value when color_valid is low.
- cfg_load:
  - Active config updates at the clock edge where cfg_load=1.
  - The new config affects grants made in the following cycle onward; a grant made in the cfg_load cycle uses the old config.
  - Config does not reset LED counters or chase_pos.
- Reset mid-operation: asserting rst_n low immediately clears everything, including in-flight responses and overflow. No response is emitted after deassertion until a new request arrives.

Test Plan:
1. Reset, cfg_load mode=0 rgb=(10,20,30), pulse strip 3 request at cycle N -> at N+2 color_valid=1, strip=3, led=0, rgb=(10,20,30); a second request yields led=1.
2. Pulse all 11 requests in one cycle, rr_ptr=0 -> 11 consecutive valid cycles with strips 0,1,...,10; overflow stays 0.
3. Mode=2, red=250, GRAD_STEP=4, strip 0 requests for led 0..2 -> red=250, 254, 2 (wrap).
4. Mode=1, green=255, strip 0 requested 60 times -> only led 0 is green, frame_done pulses with led=59. Next frame only led 1 lit; strip 2 lights led 3.
5. Strip 5 pulsed on two consecutive cycles while another strip's response blocks its grant -> overflow=1 and strip 5 answered once; rst_n low clears overflow to 0.
6. Assert rst_n low during the cycle after a grant -> color_valid stays 0, all outputs 0; strip 0's next response reports led=0.
